// File: rtl/pc_flow_ctrl_pkg.sv
// pc_flow_ctrl_pkg: shared FSM encoding, reset PC and sequential-PC helper for the fetch flow controller
package pc_flow_ctrl_pkg;
  typedef enum logic [1:0] {
    FLOW_BOOT = 2'd0,
    FLOW_RUN  = 2'd1,
    FLOW_MDW  = 2'd2
  } flow_state_e;
  localparam logic [31:0] PC_INITIAL = 32'h0000_3000;
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/pc_flow_ctrl_md_busy_timer.sv
// md_busy_timer: load/decrement counter tracking how long the mult/div unit stays busy
module md_busy_timer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy,
  output logic last
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  assign busy = cnt != '0;
  assign last = cnt == CNT_W'(1);
endmodule

// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: fetch PC sequencing, merging hazard stalls, mult/div busy stalls and taken redirects
module pc_flow_ctrl
  import pc_flow_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_INIT = PC_INITIAL,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_now,
  input  logic        hazard_stall,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        md_use_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        pc_en,
  output logic [31:0] npc,
  output logic        d_stall,
  output logic        e_flush,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);
  flow_state_e state;
  logic run, tmr_busy, md_last, stall;
  assign run = state != FLOW_BOOT;
  md_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) u_tmr (
    .clk    (clk),
    .reset  (reset),
    .load   (state == FLOW_RUN && md_start),
    .is_div (md_is_div),
    .busy   (tmr_busy),
    .last   (md_last)
  );
  assign md_busy = tmr_busy | (run & md_start);
  assign stall   = run & (hazard_stall | (md_busy & md_use_d));
  assign pc_en   = run & ~stall;
  assign d_stall = stall;
  assign e_flush = stall;
  // a stalled branch stays in D and re-presents its redirect, so stall wins over redirect
  assign npc = !run ? PC_INIT : stall ? pc_now : redirect_valid ? redirect_target : seq_pc(pc_now);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= FLOW_BOOT;
      stall_cycles <= '0;
    end else begin
      state <= state == FLOW_RUN ? (md_start ? FLOW_MDW : FLOW_RUN) :
               state == FLOW_MDW ? (md_last ? FLOW_RUN : FLOW_MDW) : FLOW_RUN;
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  a_no_restart: assert property (@(posedge clk) disable iff (!reset) !(md_start && state == FLOW_MDW));
  a_timer_sync: assert property (@(posedge clk) disable iff (!reset) (state == FLOW_MDW) == tmr_busy);
endmodule

// File: tb/tb_pc_flow_ctrl.sv
// tb_pc_flow_ctrl: directed vector table, multi-cycle corner sequences and randomized model check
module tb_pc_flow_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] pc_now, redirect_target, npc, stall_cycles;
  logic hazard_stall, md_start, md_is_div, md_use_d, redirect_valid;
  logic pc_en, d_stall, e_flush, md_busy;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  pc_flow_ctrl dut (
    .clk(clk), .reset(reset), .pc_now(pc_now), .hazard_stall(hazard_stall),
    .md_start(md_start), .md_is_div(md_is_div), .md_use_d(md_use_d),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc_en(pc_en), .npc(npc), .d_stall(d_stall), .e_flush(e_flush),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic h, ms, dv, ud, rv;
    logic [31:0] tg, pc;
    logic en;
    logic [31:0] npc;
    logic dst, busy;
    logic [31:0] sc;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mk(input logic h, ms, dv, ud, rv, input logic [31:0] tg, pc,
                              input logic en, input logic [31:0] n, input logic dst, busy,
                              input logic [31:0] sc);
    vec_t v;
    v.h = h; v.ms = ms; v.dv = dv; v.ud = ud; v.rv = rv; v.tg = tg; v.pc = pc;
    v.en = en; v.npc = n; v.dst = dst; v.busy = busy; v.sc = sc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic h, ms, dv, ud, rv, input logic [31:0] tg, pc);
    hazard_stall = h; md_start = ms; md_is_div = dv; md_use_d = ud;
    redirect_valid = rv; redirect_target = tg; pc_now = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic en, input logic [31:0] n,
                         input logic dst, busy, input logic [31:0] sc);
    chk({nm, ".pc_en"}, 32'(pc_en), 32'(en));
    chk({nm, ".npc"}, npc, n);
    chk({nm, ".d_stall"}, 32'(d_stall), 32'(dst));
    chk({nm, ".e_flush"}, 32'(e_flush), 32'(dst));
    chk({nm, ".md_busy"}, 32'(md_busy), 32'(busy));
    chk({nm, ".stall_cycles"}, stall_cycles, sc);
  endtask

  // reference model state: absolute cycle numbers rather than a counter
  int cyc, busy_end;
  bit boot;
  logic [31:0] m_sc;

  initial begin
    tbl[0]  = mk(1,0,0,1,1, 32'h3100, 32'h3000,      0, 32'h3000, 0, 0, 0);
    tbl[1]  = mk(0,0,0,0,0, 32'h0,    32'h3000,      1, 32'h3004, 0, 0, 0);
    tbl[2]  = mk(0,0,0,0,0, 32'h0,    32'h3004,      1, 32'h3008, 0, 0, 0);
    tbl[3]  = mk(1,0,0,0,1, 32'h3100, 32'h3008,      0, 32'h3008, 1, 0, 0);
    tbl[4]  = mk(0,0,0,0,1, 32'h3100, 32'h3008,      1, 32'h3100, 0, 0, 1);
    tbl[5]  = mk(0,0,0,0,0, 32'h0,    32'hFFFF_FFFC, 1, 32'h0,    0, 0, 1);
    tbl[6]  = mk(0,1,0,0,0, 32'h0,    32'h3100,      1, 32'h3104, 0, 1, 1);
    tbl[7]  = mk(0,0,0,0,0, 32'h0,    32'h3104,      1, 32'h3108, 0, 1, 1);
    tbl[8]  = mk(0,0,0,1,0, 32'h0,    32'h3108,      0, 32'h3108, 1, 1, 1);
    tbl[9]  = mk(0,0,0,1,0, 32'h0,    32'h3108,      0, 32'h3108, 1, 1, 2);
    tbl[10] = mk(0,0,0,1,0, 32'h0,    32'h3108,      0, 32'h3108, 1, 1, 3);
    tbl[11] = mk(0,0,0,1,0, 32'h0,    32'h3108,      0, 32'h3108, 1, 1, 4);
    tbl[12] = mk(0,0,0,1,0, 32'h0,    32'h3108,      1, 32'h310C, 0, 0, 5);
    tbl[13] = mk(0,0,0,0,0, 32'h0,    32'h310C,      1, 32'h3110, 0, 0, 5);

    drive(0,0,0,0,0, 32'h0, 32'h3000);
    #2;
    chk_all("reset", 0, 32'h3000, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].h, tbl[i].ms, tbl[i].dv, tbl[i].ud, tbl[i].rv, tbl[i].tg, tbl[i].pc);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].npc, tbl[i].dst, tbl[i].busy, tbl[i].sc);
      tick();
    end

    // div with no dependent D-stage op: busy t..t+10, never stalls
    for (int i = 0; i <= 11; i++) begin
      drive(0, i == 0, 1, 0, 0, 32'h0, 32'h3200 + 32'(4 * i));
      @(negedge clk);
      chk($sformatf("div_busy%0d", i), 32'(md_busy), 32'(i <= 10));
      chk($sformatf("div_pc_en%0d", i), 32'(pc_en), 32'd1);
      chk($sformatf("div_npc%0d", i), npc, 32'h3204 + 32'(4 * i));
      tick();
    end

    // reset while the div timer sits at 7
    for (int i = 0; i < 4; i++) begin
      drive(0, i == 0, 1, 0, 0, 32'h0, 32'h3400);
      tick();
    end
    reset = 1'b0;
    #1;
    chk_all("mid_reset", 0, 32'h3000, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0,0,0,0,0, 32'h0, 32'h3000);
    @(negedge clk);
    chk_all("post_boot", 0, 32'h3000, 0, 0, 0);
    tick();
    @(negedge clk);
    chk_all("post_run", 1, 32'h3004, 0, 0, 0);
    tick();

    // randomized phase against the reference model
    reset = 1'b0;
    tick();
    reset = 1'b1;
    boot = 1; cyc = 0; busy_end = -1; m_sc = 0;
    for (int i = 0; i < 400; i++) begin
      logic h, ms, dv, ud, rv, e_busy, e_stall, e_en;
      logic [31:0] tg, pc, e_npc;
      h  = $urandom_range(0, 3) == 0;
      ud = $urandom_range(0, 2) == 0;
      rv = $urandom_range(0, 3) == 0;
      dv = 1'($urandom_range(0, 1));
      tg = $urandom;
      pc = $urandom_range(0, 15) == 0 ? 32'hFFFF_FFFC : $urandom;
      ms = !boot && cyc > busy_end && $urandom_range(0, 5) == 0;
      e_busy  = !boot && (cyc <= busy_end || ms);
      e_stall = !boot && (h || (e_busy && ud));
      e_en    = !boot && !e_stall;
      e_npc   = boot ? 32'h3000 : e_stall ? pc : rv ? tg : pc + 32'd4;
      drive(h, ms, dv, ud, rv, tg, pc);
      @(negedge clk);
      chk_all($sformatf("rnd%0d", i), e_en, e_npc, e_stall, e_busy, m_sc);
      if (ms) busy_end = cyc + (dv ? 10 : 5);
      if (e_stall && m_sc != 32'hFFFF_FFFF) m_sc++;
      boot = 0;
      cyc++;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
